// File: rtl/xtimer.sv
// rtl/xtimer.sv - 32-bit prescaled down-counting timer with auto-reload and level irq
// Optional PWM compare output enabled by defining XTIMER_PWM_EN.
module xtimer #(
    parameter int DATA_W  = 32,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              we,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              irq
`ifdef XTIMER_PWM_EN
    ,
    output logic              pwm_out
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_LOAD   = 3'd1;
    localparam logic [2:0] A_COUNT  = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_CMP    = 3'd4;

    logic [0:0]         state_q, state_d;
    logic               auto_q, auto_d;
    logic               irq_en_q, irq_en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [DATA_W-1:0]  load_q, load_d;
    logic [DATA_W-1:0]  count_q, count_d;
    logic               expired_q, expired_d;
    logic               irq_q, irq_d;

    logic tick;
    logic expire;
    logic wr_ctrl, wr_load, wr_count, wr_status;

    assign wr_ctrl   = sel && we && (addr == A_CTRL);
    assign wr_load   = sel && we && (addr == A_LOAD);
    assign wr_count  = sel && we && (addr == A_COUNT);
    assign wr_status = sel && we && (addr == A_STATUS);

    // Tick fires on the clock where the prescaler counter reaches PRESC.
    assign tick = (state_q == S_RUN) && (presc_cnt_q == presc_q);

    // Next-state: ticks and expiry first, then bus writes override where they collide.
    always_comb begin
        state_d     = state_q;
        auto_d      = auto_q;
        irq_en_d    = irq_en_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        load_d      = load_q;
        count_d     = count_q;
        expire      = 1'b0;

        if (state_q == S_RUN) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
            // A COUNT write on the same edge swallows the tick entirely.
            if (tick && !wr_count) begin
                if (count_q != '0) begin
                    count_d = count_q - DATA_W'(1);
                end else begin
                    expire = 1'b1;
                    if (auto_q) begin
                        count_d = load_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        end

        if (wr_ctrl) begin
            auto_d   = data_in[1];
            irq_en_d = data_in[2];
            presc_d  = data_in[8 +: PRESC_W];
            if (data_in[0]) begin
                state_d = S_RUN;
                // Only a start from IDLE reloads; EN=1 while running just retunes fields.
                if (state_q == S_IDLE) begin
                    count_d     = load_q;
                    presc_cnt_d = '0;
                end
            end else begin
                state_d     = S_IDLE;
                presc_cnt_d = '0;
                count_d     = count_q;
            end
        end

        if (wr_load) begin
            load_d = data_in;
        end

        if (wr_count) begin
            count_d = data_in;
        end

        // Expiry set takes priority over a simultaneous write-1-to-clear.
        expired_d = expire | (expired_q & ~(wr_status & data_in[0]));
        irq_d     = expired_d & irq_en_d;
    end

    // Core timer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            auto_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            load_q      <= '0;
            count_q     <= '0;
            expired_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            auto_q      <= auto_d;
            irq_en_q    <= irq_en_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            load_q      <= load_d;
            count_q     <= count_d;
            expired_q   <= expired_d;
            irq_q       <= irq_d;
        end
    end

    assign irq = irq_q;

`ifdef XTIMER_PWM_EN
    logic [DATA_W-1:0] cmp_q;
    logic              pwm_q;

    // Compare register and registered PWM level, forced low outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            if (sel && we && (addr == A_CMP)) begin
                cmp_q <= data_in;
            end
            pwm_q <= (state_d == S_RUN) && (count_d < cmp_q);
        end
    end

    assign pwm_out = pwm_q;
`endif

    // Combinational read mux; reads zero whenever the block is not selected.
    always_comb begin
        data_out = '0;
        if (sel) begin
            case (addr)
                A_CTRL: begin
                    data_out[0]            = (state_q == S_RUN);
                    data_out[1]            = auto_q;
                    data_out[2]            = irq_en_q;
                    data_out[8 +: PRESC_W] = presc_q;
                end
                A_LOAD:   data_out = load_q;
                A_COUNT:  data_out = count_q;
                A_STATUS: data_out[0] = expired_q;
`ifdef XTIMER_PWM_EN
                A_CMP:    data_out = cmp_q;
`endif
                default:  data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xtimer.sv
// tb/tb_xtimer.sv - directed self-checking bench for xtimer
module tb_xtimer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        irq;
`ifdef XTIMER_PWM_EN
    logic        pwm_out;
`endif

    int checks = 0;
    int failures = 0;

    always #50 clk = ~clk;

    xtimer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq)
`ifdef XTIMER_PWM_EN
        ,
        .pwm_out  (pwm_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; data_in = 32'd0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        check(tag, data_out, exp);
        sel = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset values
        step(2);
        rd("rst_ctrl", 3'd0, 32'h0);
        rd("rst_load", 3'd1, 32'h0);
        rd("rst_count", 3'd2, 32'h0);
        rd("rst_status", 3'd3, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot: LOAD=3, EN|IRQ_EN, PRESC=0 -> expiry 4 edges after start
        wr(3'd1, 32'd3);
        wr(3'd0, 32'h5);
        rd("os_count_start", 3'd2, 32'd3);
        step(3);
        rd("os_count_e3", 3'd2, 32'd0);
        rd("os_status_e3", 3'd3, 32'd0);
        check("os_irq_e3", {31'd0, irq}, 32'd0);
        step(1);
        rd("os_status_exp", 3'd3, 32'd1);
        rd("os_ctrl_exp", 3'd0, 32'h4);
        rd("os_count_exp", 3'd2, 32'd0);
        check("os_irq_exp", {31'd0, irq}, 32'd1);
        step(2);
        rd("os_count_idle", 3'd2, 32'd0);
        check("os_irq_held", {31'd0, irq}, 32'd1);
        wr(3'd3, 32'd1);
        rd("os_status_clr", 3'd3, 32'd0);
        check("os_irq_clr", {31'd0, irq}, 32'd0);

        // Auto-reload: LOAD=1, EN|AUTO, PRESC=2 -> expiry every 6 clocks
        wr(3'd1, 32'd1);
        wr(3'd0, 32'h203);
        step(5);
        rd("ar_status_e5", 3'd3, 32'd0);
        rd("ar_count_e5", 3'd2, 32'd0);
        step(1);
        rd("ar_status_e6", 3'd3, 32'd1);
        rd("ar_count_reload", 3'd2, 32'd1);
        rd("ar_ctrl", 3'd0, 32'h203);
        check("ar_irq_masked", {31'd0, irq}, 32'd0);
        wr(3'd3, 32'd1);
        rd("ar_status_clr", 3'd3, 32'd0);
        step(4);
        rd("ar_status_e11", 3'd3, 32'd0);
        step(1);
        rd("ar_status_e12", 3'd3, 32'd1);
        step(5);
        wr(3'd3, 32'd1);
        rd("col_w1c_on_expiry", 3'd3, 32'd1);
        rd("col_count_e18", 3'd2, 32'd1);
        step(2);
        wr(3'd2, 32'h20);
        rd("col_count_on_tick", 3'd2, 32'h20);
        step(2);
        rd("col_count_e23", 3'd2, 32'h20);
        step(1);
        rd("col_count_e24", 3'd2, 32'h1f);
        wr(3'd0, 32'h200);
        rd("stop_count", 3'd2, 32'h1f);
        step(6);
        rd("stop_count_hold", 3'd2, 32'h1f);
        rd("stop_ctrl", 3'd0, 32'h200);

        // Bus decode
        wr(3'd3, 32'd1);
        rd("dec_status", 3'd3, 32'd0);
        rd("dec_rd5", 3'd5, 32'd0);
        rd("dec_rd6", 3'd6, 32'd0);
        rd("dec_rd7", 3'd7, 32'd0);
        addr = 3'd1;
        sel = 1'b0;
        #1;
        check("dec_nosel", data_out, 32'd0);
        wr(3'd6, 32'hffff_ffff);
        wr(3'd5, 32'hffff_ffff);
`ifndef XTIMER_PWM_EN
        wr(3'd4, 32'hffff_ffff);
        rd("dec_rd4", 3'd4, 32'd0);
`endif
        rd("dec_ctrl", 3'd0, 32'h200);
        rd("dec_load", 3'd1, 32'd1);
        rd("dec_count", 3'd2, 32'h1f);
        rd("dec_status2", 3'd3, 32'd0);

`ifdef XTIMER_PWM_EN
        // PWM: LOAD=3, CMP=2, AUTO -> high 2 of every 4 clocks
        begin
            logic [7:0] pat;
            pat = 8'b0110_0110;
            check("pwm_idle", {31'd0, pwm_out}, 32'd0);
            wr(3'd4, 32'd2);
            rd("pwm_cmp", 3'd4, 32'd2);
            wr(3'd1, 32'd3);
            wr(3'd0, 32'h3);
            check("pwm_e0", {31'd0, pwm_out}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                step(1);
                check("pwm_pattern", {31'd0, pwm_out}, {31'd0, pat[7-i]});
            end
            wr(3'd4, 32'd0);
            for (int i = 0; i < 4; i++) begin
                step(1);
                check("pwm_cmp0", {31'd0, pwm_out}, 32'd0);
            end
            wr(3'd4, 32'd2);
            step(3);
            wr(3'd0, 32'h0);
            check("pwm_disable", {31'd0, pwm_out}, 32'd0);
        end
`endif

        // Async reset mid-RUN with COUNT=0x10 and irq high
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h5);
        step(1);
        check("ar0_irq", {31'd0, irq}, 32'd1);
        wr(3'd1, 32'h10);
        wr(3'd0, 32'hff05);
        rd("prerst_count", 3'd2, 32'h10);
        check("prerst_irq", {31'd0, irq}, 32'd1);
        #10;
        rst_n = 1'b0;
        #1;
        check("arst_irq", {31'd0, irq}, 32'd0);
        rd("arst_ctrl", 3'd0, 32'h0);
        rd("arst_load", 3'd1, 32'h0);
        rd("arst_count", 3'd2, 32'h0);
        rd("arst_status", 3'd3, 32'h0);
`ifdef XTIMER_PWM_EN
        rd("arst_cmp", 3'd4, 32'h0);
        check("arst_pwm", {31'd0, pwm_out}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        rd("post_rst_count", 3'd2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
